// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its consumers.
//   N_DEFAULT      default multiplier operand width (product is 2*N bits)
//   LEN_DEFAULT    default number of products per dot product
//   acc_w_of()     accumulator width derived from the operand width
//   out_state_e    output-register FSM encoding (EMPTY / FULL)
//   sat_pos_limit / sat_neg_limit
//                  signed saturation limits for a given width. They are returned
//                  in a wide vector; callers truncate to their own width.
package booth_pkg;

  localparam int unsigned N_DEFAULT   = 32'd32;
  localparam int unsigned LEN_DEFAULT = 32'd16;
  localparam int unsigned LIM_VEC_W   = 32'd256;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Eight guard bits above the full product width before saturation can occur.
  function automatic int unsigned acc_w_of(input int unsigned n);
    return (32'd2 * n) + 32'd8;
  endfunction

  // +(2^(w-1)-1): all ones below the sign bit.
  function automatic logic [LIM_VEC_W-1:0] sat_pos_limit(input int unsigned w);
    logic [LIM_VEC_W-1:0] v;
    v = {LIM_VEC_W{1'b0}};
    for (int unsigned i = 32'd0; i < LIM_VEC_W; i++) begin
      if (i < (w - 32'd1)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // -2^(w-1): sign bit set, zeros below; upper bits sign-extended.
  function automatic logic [LIM_VEC_W-1:0] sat_neg_limit(input int unsigned w);
    logic [LIM_VEC_W-1:0] v;
    v = {LIM_VEC_W{1'b1}};
    for (int unsigned i = 32'd0; i < LIM_VEC_W; i++) begin
      if (i < (w - 32'd1)) begin
        v[i] = 1'b0;
      end else begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational signed saturating adder.
//   a, b  in  W  signed two's-complement addends
//   y     out W  a+b, clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf   out 1  the true sum did not fit in W bits (y was clamped)
module sat_add_signed
  import booth_pkg::*;
#(
  parameter int unsigned W = 32'd16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [W-1:0] POS_LIM = W'(sat_pos_limit(W));
  localparam logic [W-1:0] NEG_LIM = W'(sat_neg_limit(W));

  logic [W:0] wide_s;

  // One-bit-wider add; the two top bits disagree exactly when W bits overflow,
  // and the extra top bit gives the true sign of the result.
  always_comb begin
    wide_s = {a[W-1], a} + {b[W-1], b};
    if (wide_s[W] != wide_s[W-1]) begin
      ovf = 1'b1;
      if (wide_s[W] == 1'b0) begin
        y = POS_LIM;
      end else begin
        y = NEG_LIM;
      end
    end else begin
      ovf = 1'b0;
      y   = wide_s[W-1:0];
    end
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Saturating dot-product accumulator behind the sequential Booth multiplier.
// Every mul_done pulse adds the sign-extended product to the running sum; the
// LEN-th product completes the sum, which is handed to a one-entry valid/ready
// output register. The input side never stalls: a finished sum arriving while
// the output still holds an unaccepted one is dropped and flagged in drop_err.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clr          synchronous clear of accumulation and output state
//   mul_done     product strobe; mul_c is the signed 2*N-bit product
//   out_valid    out_data/out_sat hold a finished sum
//   out_ready    consumer accepts when out_valid && out_ready
//   out_data     signed saturated sum (ACC_W bits)
//   out_sat      the sum saturated at least once
//   drop_err     sticky: a finished sum was lost to backpressure
//   term_cnt     products already accumulated in the current sum
module booth_mac_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned ACC_W = acc_w_of(N),
  parameter int unsigned LEN   = LEN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       mul_done,
  input  logic [2*N-1:0]             mul_c,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic                       out_sat,
  output logic                       drop_err,
  output logic [$clog2(LEN+1)-1:0]   term_cnt
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(LEN - 32'd1);

  logic [ACC_W-1:0] acc_q,      acc_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic             sat_pend_q, sat_pend_d;
  out_state_e       state_q,    state_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q,  out_sat_d;
  logic             drop_err_q, drop_err_d;

  logic [ACC_W-1:0] prod_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic             ovf_s;
  logic             last_term_s;
  logic             finish_s;
  logic             handshake_s;
  logic             fin_sat_s;

  // Sign-extend the product to the accumulator width.
  assign prod_ext_s = ACC_W'($signed(mul_c));

  sat_add_signed #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext_s),
    .y   (sum_s),
    .ovf (ovf_s)
  );

  assign last_term_s = (term_cnt_q == LAST_TERM);
  assign finish_s    = mul_done & last_term_s;
  assign handshake_s = (state_q == OUT_FULL) & out_ready;
  // Saturation anywhere in the sum, including on the final term itself.
  assign fin_sat_s   = sat_pend_q | ovf_s;

  // Next-state for the accumulator, term counter and output register/FSM.
  always_comb begin
    acc_d      = acc_q;
    term_cnt_d = term_cnt_q;
    sat_pend_d = sat_pend_q;
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    drop_err_d = drop_err_q;

    if (clr) begin
      // clr wins over everything, including a coincident mul_done.
      acc_d      = {ACC_W{1'b0}};
      term_cnt_d = {CNT_W{1'b0}};
      sat_pend_d = 1'b0;
      state_d    = OUT_EMPTY;
      out_sat_d  = 1'b0;
      drop_err_d = 1'b0;
    end else begin
      if (mul_done) begin
        if (last_term_s) begin
          acc_d      = {ACC_W{1'b0}};
          term_cnt_d = {CNT_W{1'b0}};
          sat_pend_d = 1'b0;
        end else begin
          acc_d      = sum_s;
          term_cnt_d = term_cnt_q + CNT_W'(1'b1);
          sat_pend_d = fin_sat_s;
        end
      end else begin
        acc_d = acc_q;
      end

      case (state_q)
        OUT_EMPTY: begin
          if (finish_s) begin
            state_d    = OUT_FULL;
            out_data_d = sum_s;
            out_sat_d  = fin_sat_s;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
        OUT_FULL: begin
          if (finish_s && handshake_s) begin
            // Old sum leaves while the new one arrives: reload without a bubble.
            state_d    = OUT_FULL;
            out_data_d = sum_s;
            out_sat_d  = fin_sat_s;
          end else if (finish_s) begin
            // Nowhere to put the new sum; keep the old one and flag the loss.
            state_d    = OUT_FULL;
            drop_err_d = 1'b1;
          end else if (handshake_s) begin
            state_d = OUT_EMPTY;
          end else begin
            state_d = OUT_FULL;
          end
        end
        default: begin
          state_d = OUT_EMPTY;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= {ACC_W{1'b0}};
      term_cnt_q <= {CNT_W{1'b0}};
      sat_pend_q <= 1'b0;
      state_q    <= OUT_EMPTY;
      out_data_q <= {ACC_W{1'b0}};
      out_sat_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      term_cnt_q <= term_cnt_d;
      sat_pend_q <= sat_pend_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      drop_err_q <= drop_err_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign drop_err  = drop_err_q;
  assign term_cnt  = term_cnt_q;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
module tb_booth_mac_accumulator;

  localparam int unsigned N     = 8;
  localparam int unsigned ACC_W = 16;
  localparam int unsigned LEN   = 4;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              mul_done;
  logic [2*N-1:0]    mul_c;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_sat;
  logic              drop_err;
  logic [2:0]        term_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: a running integer sum and a one-entry output slot.
  int m_acc, m_cnt, m_data;
  bit m_satp, m_valid, m_sat, m_drop;

  booth_mac_accumulator #(.N(N), .ACC_W(ACC_W), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .mul_done  (mul_done),
    .mul_c     (mul_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .drop_err  (drop_err),
    .term_cnt  (term_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_satp = 1'b0;
    m_valid = 1'b0; m_data = 0; m_sat = 1'b0; m_drop = 1'b0;
  endtask

  task automatic model_edge(input bit d, input int c, input bit rdy, input bit cl);
    int  s;
    bit  ov, fin, fsat, hs;
    int  fsum;
    if (cl) begin
      m_acc = 0; m_cnt = 0; m_satp = 1'b0;
      m_valid = 1'b0; m_sat = 1'b0; m_drop = 1'b0;
    end else begin
      hs = m_valid && rdy;
      fin = 1'b0; fsum = 0; fsat = 1'b0;
      if (d) begin
        s = m_acc + c;
        ov = 1'b0;
        if (s > SAT_MAX) begin s = SAT_MAX; ov = 1'b1; end
        if (s < SAT_MIN) begin s = SAT_MIN; ov = 1'b1; end
        if (m_cnt == LEN - 1) begin
          fin = 1'b1; fsum = s; fsat = m_satp | ov;
          m_acc = 0; m_cnt = 0; m_satp = 1'b0;
        end else begin
          m_acc = s; m_cnt = m_cnt + 1; m_satp = m_satp | ov;
        end
      end
      if (fin) begin
        if (!m_valid || hs) begin
          m_valid = 1'b1; m_data = fsum; m_sat = fsat;
        end else begin
          m_drop = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model on the edge, sample 1 ns later.
  task automatic step(input bit d, input int c, input bit rdy, input bit cl);
    mul_done  = d;
    mul_c     = 16'(c);
    out_ready = rdy;
    clr       = cl;
    @(posedge clk);
    model_edge(d, c, rdy, cl);
    #1;
    mul_done = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; mul_done = 1'b0; mul_c = 16'h0000; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0);
    n_vec++;
    if ({out_valid, out_sat, drop_err} !== 3'b000 || out_data !== 16'h0000 || term_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%0b sat=%0b drop=%0b data=%0h cnt=%0d want all 0",
               out_valid, out_sat, drop_err, out_data, term_cnt);
    end
  endtask

  task automatic test_basic_sum();
    int prods [4] = '{15, -14, 100, 1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, prods[i], 1'b1, 1'b0);
      if (i == 2) begin
        n_vec++;
        if (out_valid !== 1'b0 || term_cnt !== 3'd3) begin
          n_err++;
          $display("FAIL basic_mid: got valid=%0b cnt=%0d want valid=0 cnt=3", out_valid, term_cnt);
        end
      end
    end
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 102 || out_sat !== 1'b0 || term_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL basic_sum: got valid=%0b data=%0d sat=%0b cnt=%0d want 1/102/0/0",
               out_valid, $signed(out_data), out_sat, term_cnt);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_drain: got valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    int clean [4] = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) step(1'b1, 16129, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 32767 || out_sat !== 1'b1) begin
      n_err++;
      $display("FAIL sat_pos: got valid=%0b data=%0d sat=%0b want 1/32767/1",
               out_valid, $signed(out_data), out_sat);
    end
    for (int i = 0; i < 4; i++) step(1'b1, -16256, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != -32768 || out_sat !== 1'b1) begin
      n_err++;
      $display("FAIL sat_neg: got valid=%0b data=%0d sat=%0b want 1/-32768/1",
               out_valid, $signed(out_data), out_sat);
    end
    for (int i = 0; i < 4; i++) step(1'b1, clean[i], 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 10 || out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL sat_clean: got valid=%0b data=%0d sat=%0b want 1/10/0",
               out_valid, $signed(out_data), out_sat);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure_drop();
    step(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 4 || drop_err !== 1'b1) begin
      n_err++;
      $display("FAIL drop_hold: got valid=%0b data=%0d drop=%0b want 1/4/1",
               out_valid, $signed(out_data), drop_err);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b0 || drop_err !== 1'b1) begin
      n_err++;
      $display("FAIL drop_drain: got valid=%0b drop=%0b want 0/1", out_valid, drop_err);
    end
    step(1'b0, 0, 1'b1, 1'b1);
    n_vec++;
    if (drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL drop_clr: got drop=%0b want 0", drop_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 4) begin
      n_err++;
      $display("FAIL b2b_first: got valid=%0b data=%0d want 1/4", out_valid, $signed(out_data));
    end
    step(1'b1, 2, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 8 || drop_err !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_reload: got valid=%0b data=%0d drop=%0b want 1/8/0",
               out_valid, $signed(out_data), drop_err);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 7, 1'b1, 1'b1);
    n_vec++;
    if (term_cnt !== 3'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clr_state: got cnt=%0d valid=%0b want 0/0", term_cnt, out_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 4) begin
      n_err++;
      $display("FAIL clr_after: got valid=%0b data=%0d want 1/4", out_valid, $signed(out_data));
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 1'b0);
    n_vec++;
    if (term_cnt !== 3'd2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre: got cnt=%0d valid=%0b want 2/1", term_cnt, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({out_valid, out_sat, drop_err} !== 3'b000 || out_data !== 16'h0000 || term_cnt !== 3'd0) begin
      n_err++;
      $display("FAIL arst_now: got valid=%0b sat=%0b drop=%0b data=%0h cnt=%0d want all 0",
               out_valid, out_sat, drop_err, out_data, term_cnt);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 3, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || int'($signed(out_data)) != 12 || out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL arst_after: got valid=%0b data=%0d sat=%0b want 1/12/0",
               out_valid, $signed(out_data), out_sat);
    end
    step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit              d, rdy, cl;
    logic [15:0]     r;
    logic signed [15:0] cv;
    int              c;
    for (int i = 0; i < 600; i++) begin
      d   = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      cl  = ($urandom_range(0, 59) == 0);
      r   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cv = r;
      end else begin
        cv = 16'($signed(int'($urandom_range(0, 1000)) - 500));
      end
      c = int'(cv);
      step(d, c, rdy, cl);
      n_vec++;
      if (out_valid !== m_valid || drop_err !== m_drop || int'(term_cnt) != m_cnt ||
          (m_valid && (out_sat !== m_sat || int'($signed(out_data)) != m_data))) begin
        n_err++;
        $display("FAIL rand[%0d]: got v=%0b d=%0d s=%0b drop=%0b cnt=%0d want v=%0b d=%0d s=%0b drop=%0b cnt=%0d",
                 i, out_valid, $signed(out_data), out_sat, drop_err, term_cnt,
                 m_valid, m_data, m_sat, m_drop, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_saturation();
    test_backpressure_drop();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
